// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between instruction fetch
// and load/store. It registers the memory handshake and aborts a transaction after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic       FETCH    = 1'b0;
    localparam logic       DATA     = 1'b1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_d;
    logic       last_grant;
    logic [7:0] tmo_cnt;
    logic       i_pend, d_pend;
    logic       gnt_i, gnt_d, ack_hit, tmo_hit;

    // A request whose done is pulsing this cycle has been served. The requester only
    // drops it at the end of this cycle, so it must not be granted a second time.
    assign i_pend = i_req & ~i_done;
    assign d_pend = d_req & ~d_done;
    assign stall  = i_pend | d_pend;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && (!i_pend || last_grant == FETCH)) begin
                    gnt_d   = 1'b1;
                    state_d = GNT_D;
                end else if (i_pend) begin
                    gnt_i   = 1'b1;
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= FETCH;
            tmo_cnt    <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            mem_valid <= (state_d != IDLE);
            i_done    <= (state == GNT_I) && (ack_hit || tmo_hit);
            d_done    <= (state == GNT_D) && (ack_hit || tmo_hit);

            if (gnt_i) begin
                mem_addr   <= i_addr;
                mem_we     <= 1'b0;
                mem_wdata  <= '0;
                last_grant <= FETCH;
                tmo_cnt    <= '0;
            end else if (gnt_d) begin
                mem_addr   <= d_addr;
                mem_we     <= d_we;
                mem_wdata  <= d_wdata;
                last_grant <= DATA;
                tmo_cnt    <= '0;
            end else if (state != IDLE && !mem_ack) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            // An aborted transaction returns zero data rather than whatever is on the bus.
            if (ack_hit || tmo_hit) begin
                if (state == GNT_I) i_rdata <= ack_hit ? mem_rdata : '0;
                else                d_rdata <= ack_hit ? mem_rdata : '0;
            end

            if (tmo_hit) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A behavioural memory acks after a programmable delay,
// and monitors compare grants and done pulses against queued expectations.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
    } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_valid, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, err;

    int total = 0;
    int bad   = 0;

    gnt_t  exp_gnt_q[$];
    done_t exp_i_q[$];
    done_t exp_d_q[$];

    logic [31:0] mem [logic [31:0]];
    int   ack_dly   = 1;
    logic stray_ack = 1'b0;
    int   last_len  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_grant(input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_gnt_q.push_back('{we, a, wd});
    endtask

    // Memory model: acks ack_dly cycles after mem_valid first appears
    initial begin
        int k = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
                stray_ack = 1'b0;
            end else if (mem_valid) begin
                if (k == ack_dly) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    k = 0;
                end else begin
                    k++;
                end
            end else begin
                k = 0;
            end
        end
    end

    // Monitor: grants, address stability and done pulses
    initial begin
        logic        prev_valid = 1'b0;
        logic        prev_i = 1'b0, prev_d = 1'b0;
        logic [31:0] cap_addr = '0;
        int          vlen = 0;
        gnt_t        g;
        done_t       e;
        forever begin
            @(negedge clk);
            if (mem_valid && !prev_valid) begin
                if (exp_gnt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL gnt_unexpected: got addr %h expected no grant", mem_addr);
                end else begin
                    g = exp_gnt_q.pop_front();
                    chk("gnt_we", {31'b0, mem_we}, {31'b0, g.we});
                    chk("gnt_addr", mem_addr, g.addr);
                    if (g.we) chk("gnt_wdata", mem_wdata, g.wdata);
                end
                cap_addr = mem_addr;
                vlen     = 1;
            end else if (mem_valid) begin
                chk("addr_stable", mem_addr, cap_addr);
                vlen++;
            end
            if (!mem_valid && prev_valid) last_len = vlen;
            prev_valid = mem_valid;

            if (i_done) begin
                chk("i_done_width", {31'b0, prev_i}, 32'd0);
                if (exp_i_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL i_done_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    e = exp_i_q.pop_front();
                    if (e.chk) chk("i_rdata", i_rdata, e.rdata);
                end
            end
            if (d_done) begin
                chk("d_done_width", {31'b0, prev_d}, 32'd0);
                if (exp_d_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d_done_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    e = exp_d_q.pop_front();
                    if (e.chk) chk("d_rdata", d_rdata, e.rdata);
                end
            end
            prev_i = i_done;
            prev_d = d_done;
        end
    end

    // Drives are applied at +1 after the edge and observations are taken at +2.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat);
        int   n = 0;
        logic got = 1'b0;
        exp_i_q.push_back('{1'b1, exp});
        i_addr = a;
        i_req  = 1'b1;
        while (!got && n < 100) begin
            @(posedge clk);
            #2;
            n++;
            if (i_done) got = 1'b1;
            else        chk("i_stall_wait", {31'b0, stall}, 32'd1);
        end
        chk("i_done_seen", {31'b0, got}, 32'd1);
        if (got && lat >= 0) chk("i_latency", n, lat);
        if (got && !d_req)   chk("i_stall_done", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp, input logic c, input int lat);
        int   n = 0;
        logic got = 1'b0;
        exp_d_q.push_back('{c, exp});
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        while (!got && n < 100) begin
            @(posedge clk);
            #2;
            n++;
            if (d_done) got = 1'b1;
            else        chk("d_stall_wait", {31'b0, stall}, 32'd1);
        end
        chk("d_done_seen", {31'b0, got}, 32'd1);
        if (got && lat >= 0) chk("d_latency", n, lat);
        if (got && !i_req)   chk("d_stall_done", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[32'h0]   = 32'h00000013;
        mem[32'h4]   = 32'h00100093;
        mem[32'h10]  = 32'h00500093;
        mem[32'h20]  = 32'h00a00113;
        mem[32'h100] = 32'h11112222;
        mem[32'h104] = 32'h33334444;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_done", {30'b0, i_done, d_done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        // Contention on the first cycle after reset: data wins, then strict alternation
        ack_dly = 1;
        exp_grant(1'b0, 32'h100, 32'h0);
        exp_grant(1'b0, 32'h0, 32'h0);
        fork
            do_data(1'b0, 32'h100, 32'h0, 32'h11112222, 1'b1, -1);
            do_fetch(32'h0, 32'h00000013, -1);
        join
        exp_grant(1'b0, 32'h104, 32'h0);
        exp_grant(1'b0, 32'h4, 32'h0);
        fork
            do_data(1'b0, 32'h104, 32'h0, 32'h33334444, 1'b1, -1);
            do_fetch(32'h4, 32'h00100093, -1);
        join

        // Single fetch, ack one cycle after mem_valid
        exp_grant(1'b0, 32'h10, 32'h0);
        do_fetch(32'h10, 32'h00500093, 3);

        // Store then load
        exp_grant(1'b1, 32'h40, 32'hDEADBEEF);
        do_data(1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        exp_grant(1'b0, 32'h40, 32'h0);
        do_data(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, 3);

        // Variable ack latency
        ack_dly = 0;
        exp_grant(1'b0, 32'h20, 32'h0);
        do_fetch(32'h20, 32'h00a00113, 2);
        ack_dly = 3;
        exp_grant(1'b0, 32'h104, 32'h0);
        do_data(1'b0, 32'h104, 32'h0, 32'h33334444, 1'b1, 5);
        ack_dly = 7;
        exp_grant(1'b1, 32'h200, 32'hCAFEF00D);
        do_data(1'b1, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0, 9);
        chk("mem_len_dly7", last_len, 8);
        ack_dly = 0;
        exp_grant(1'b0, 32'h200, 32'h0);
        do_data(1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b1, 2);

        // Timeout: memory never answers
        chk("err_pre_timeout", {31'b0, err}, 32'd0);
        ack_dly = 255;
        exp_grant(1'b0, 32'h80, 32'h0);
        do_fetch(32'h80, 32'h0, 16);
        chk("tmo_valid_len", last_len, 15);
        chk("tmo_err", {31'b0, err}, 32'd1);
        chk("tmo_valid_drop", {31'b0, mem_valid}, 32'd0);
        stray_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("err_sticky", {31'b0, err}, 32'd1);
        chk("stray_no_grant", {31'b0, mem_valid}, 32'd0);

        // Reset while a load is waiting on memory
        exp_grant(1'b0, 32'h44, 32'h0);
        d_we = 1'b0; d_addr = 32'h44; d_req = 1'b1;
        for (int n = 0; n < 10 && !mem_valid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_granted", {31'b0, mem_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_mid_d_done", {31'b0, d_done}, 32'd0);
        chk("rst_mid_err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        ack_dly = 1;
        exp_grant(1'b0, 32'h10, 32'h0);
        do_fetch(32'h10, 32'h00500093, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_q_drained", exp_gnt_q.size(), 0);
        chk("i_q_drained", exp_i_q.size(), 0);
        chk("d_q_drained", exp_d_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch path and the load/store path of the RV32I core.
- Arbitrates requests, drives the memory request/response handshake and returns responses to the winning requester.
- Detects a memory that never responds and raises a sticky error.
- The core stalls its program counter while either requester is waiting.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
TIMEOUT, 15, maximum cycles a granted transaction may wait for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_done
i_addr  in  AW  fetch address (pc)
i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DW  fetched instruction
d_req  in  1  data request, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address (alu result)
d_wdata  in  DW  store data
d_done  out  1  one-cycle pulse: data access complete, d_rdata valid for loads
d_rdata  out  DW  load data
mem_valid  out  1  request to memory
mem_we  out  1  write enable to memory
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ack  in  1  memory response; single-cycle pulse, mem_rdata valid same cycle
mem_rdata  in  DW  memory read data
stall  out  1  freeze pc/pipeline: (i_req & ~i_done) | (d_req & ~d_done)
err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values: state=IDLE, last_grant=FETCH, all outputs 0, timeout counter 0, err 0.
- States: IDLE, GNT_I, GNT_D.
- IDLE, one request pending -> grant it.
- IDLE, both pending -> grant the one not in last_grant (round-robin). After reset, data wins the first tie.
- Grant action: latch addr, we and wdata into registers. Next state is GNT_I/GNT_D. Update last_grant.
- IDLE, no request -> stay.
- Memory outputs are registered. mem_valid=1 throughout GNT_I/GNT_D. mem_addr, mem_we and mem_wdata stay stable while mem_valid=1.
- In GNT_I, mem_we=0 always.
- GNT_x with mem_ack=1: complete the transaction.
  - Pulse x_done for exactly one cycle, the cycle after ack.
  - Register mem_rdata into x_rdata. x_rdata holds until the next completion for that requester.
  - Return to IDLE.
- Earliest-ack latency: request sampled in cycle N -> mem_valid in N+1 -> ack in N+1 -> done in N+2. Minimum request-to-done latency is 2 cycles.
- Back-to-back: a new grant may be issued in the same cycle done pulses (IDLE re-arbitrates that cycle). No idle bubble is required beyond the IDLE state cycle.
- Timeout counter: cleared on grant, increments each GNT cycle without ack.
- Timeout: when the count reaches TIMEOUT without ack:
  - Set err=1.
  - Pulse x_done with x_rdata=0.
  - Drop mem_valid.
  - Return to IDLE.
  - A late mem_ack arriving in IDLE is ignored.
- mem_ack in IDLE is ignored; no state change, no done pulse.
- Requester deasserting x_req mid-transaction is illegal. The arbiter still completes the transaction and pulses done.
- Reset asserted mid-transaction: all state returns to reset values on that edge, and the in-flight transaction is abandoned silently.
- stall is combinational from req and registered done. It must be 0 in the cycle done pulses so the pc advances exactly once.

Test Plan:
- Single fetch: i_addr=0x10, i_req=1; memory acks 1 cycle after mem_valid with 0x00500093 -> mem_addr=0x10, mem_we=0; i_done pulses one cycle later with i_rdata=0x00500093; stall high until then.
- Store then load: d_req with d_we=1, addr=0x40, wdata=0xDEADBEEF; then d_we=0, addr=0x40 -> first transaction mem_we=1 with mem_wdata=0xDEADBEEF; load returns d_rdata=0xDEADBEEF; each d_done is exactly one cycle.
- Contention: i_req and d_req asserted together on the first cycle after reset -> data granted first, fetch second; repeated simultaneous requests alternate D,I,D,I across 4 grants.
- Variable latency: ack delayed 0, 3 and 7 cycles -> mem_addr stable throughout; exactly one done per transaction; no extra grants.
- Timeout: TIMEOUT=15, memory never acks -> at the 15th wait cycle err=1, i_done pulses with i_rdata=0, mem_valid drops; a later stray mem_ack causes no done; err stays 1 until reset.
- Reset mid-transaction: reset in GNT_D while waiting -> next cycle mem_valid=0, d_done=0, err=0, state IDLE; a subsequent fetch completes normally.
